// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
// Arbitrates execute- and writeback-stage PC redirects into a single
// TAKE_BRANCH pulse for the fetch unit. It holds a redirect that arrives
// during a stall and keeps flush_o asserted for FLUSH_CYCLES cycles
// after each redirect is issued.
// Optional feature macro: REDIRECT_ALIGN_CHECK_EN. When it is defined,
// bit 0 of the redirect target is cleared and flagged on misaligned_o.
module fetch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_pipeline_i,
  input  logic        ex_redirect_valid_i,
  input  logic [31:0] ex_redirect_pc_i,
  input  logic        wb_redirect_valid_i,
  input  logic [31:0] wb_redirect_pc_i,
  output logic        take_branch_o,
  output logic [31:0] branch_pc_value_o,
  output logic        flush_o,
  output logic        misaligned_o
);

  localparam logic       STALL_PIPELINE = 1'b1;
  localparam logic       TAKE_BRANCH    = 1'b1;
  localparam logic [2:0] CNT_INIT       = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // With a single flush cycle, the issue cycle covers the whole flush.
  localparam state_e ISSUE_NEXT = (FLUSH_CYCLES == 1) ? RUN : FLUSH;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pend_q, pend_d;

  logic        stalled;
  logic        any_valid;
  logic [31:0] sel_tgt;
  logic        take;
  logic        flush;
  logic [31:0] raw_tgt;

  // The counter stops at zero; it never wraps.
  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  assign stalled   = (stall_pipeline_i == STALL_PIPELINE);
  assign any_valid = wb_redirect_valid_i | ex_redirect_valid_i;
  // The writeback instruction is older, so its redirect has priority.
  assign sel_tgt   = wb_redirect_valid_i ? wb_redirect_pc_i : ex_redirect_pc_i;

  // State, flush counter and pending target registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      pend_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic and the raw issue/flush decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    take    = 1'b0;
    flush   = 1'b0;
    raw_tgt = pend_q;
    unique case (state_q)
      RUN: begin
        if (any_valid) begin
          flush = 1'b1;
          if (!stalled) begin
            take    = 1'b1;
            raw_tgt = sel_tgt;
            state_d = ISSUE_NEXT;
            cnt_d   = CNT_INIT;
          end else begin
            pend_d  = sel_tgt;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        flush = 1'b1;
        if (stalled) begin
          // An ex redirect here comes from a younger, squashed instruction.
          if (wb_redirect_valid_i) pend_d = wb_redirect_pc_i;
        end else begin
          take    = 1'b1;
          raw_tgt = wb_redirect_valid_i ? wb_redirect_pc_i : pend_q;
          state_d = ISSUE_NEXT;
          cnt_d   = CNT_INIT;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (wb_redirect_valid_i) begin
          if (!stalled) begin
            take    = 1'b1;
            raw_tgt = wb_redirect_pc_i;
            state_d = ISSUE_NEXT;
            cnt_d   = CNT_INIT;
          end else begin
            pend_d  = wb_redirect_pc_i;
            state_d = HOLD;
          end
        end else if (!stalled) begin
          cnt_d = sat_dec(cnt_q);
          if (cnt_d == 3'd0) state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Output shaping: optional alignment check, with all outputs held quiet during reset.
  always_comb begin
    take_branch_o     = ~TAKE_BRANCH;
    flush_o           = 1'b0;
    misaligned_o      = 1'b0;
    branch_pc_value_o = 32'd0;
    if (!reset_i) begin
      take_branch_o = take ? TAKE_BRANCH : ~TAKE_BRANCH;
      flush_o       = flush;
`ifdef REDIRECT_ALIGN_CHECK_EN
      branch_pc_value_o = {raw_tgt[31:1], 1'b0};
      misaligned_o      = take & raw_tgt[0];
`else
      branch_pc_value_o = raw_tgt;
      misaligned_o      = 1'b0;
`endif
    end
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 SHALL have parameter: FLUSH_CYCLES, default 2, number of cycles flush_o is asserted per redirect (legal 1..7).
REQ-002 SHALL have port: clk_i  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset_i  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: stall_pipeline_i  in  stall_pipeline_sig  STALL_PIPELINE means PC and front end are frozen this cycle.
REQ-005 SHALL have port: ex_redirect_valid_i  in  1  execute-stage taken branch request.
REQ-006 SHALL have port: ex_redirect_pc_i  in  WORD  execute-stage target address.
REQ-007 SHALL have port: wb_redirect_valid_i  in  1  writeback-stage PC write request (pop/ldr to r15).
REQ-008 SHALL have port: wb_redirect_pc_i  in  WORD  writeback-stage target address.
REQ-009 SHALL have port: take_branch_o  out  take_branch_ctrl_sig  TAKE_BRANCH loads branch_pc_value_o into the PC at the next edge.
REQ-010 SHALL have port: branch_pc_value_o  out  WORD  redirect target.
REQ-011 SHALL have port: flush_o  out  1  squash all younger fetched/decoded instructions.
REQ-012 SHALL have port: misaligned_o  out  1  selected target had bit 0 set (see Configuration).

Function
REQ-013 SHALL implement states RUN, HOLD, FLUSH.
REQ-014 SHALL give wb redirect priority over ex redirect when both are valid in the same cycle (older instruction wins).
REQ-015 RUN, not stalled, redirect valid: take_branch_o=TAKE_BRANCH and branch_pc_value_o=selected target combinationally in the same cycle, flush_o=1; next state FLUSH with counter=FLUSH_CYCLES-1, or RUN if FLUSH_CYCLES=1.
REQ-016 RUN, stalled, redirect valid: SHALL latch selected target into a pending register, take_branch_o not TAKE_BRANCH, flush_o=1; next state HOLD.
REQ-017 HOLD, stalled: SHALL keep pending target and flush_o=1; a valid wb redirect SHALL overwrite a pending ex target; an ex redirect SHALL be ignored.
REQ-018 HOLD, not stalled: take_branch_o=TAKE_BRANCH with pending target (or a same-cycle wb target, which overrides), flush_o=1; then transition exactly as REQ-015.
REQ-019 FLUSH: flush_o=1; counter SHALL decrement only on non-stalled cycles; at counter 0 plus a non-stalled cycle, SHALL return to RUN.
REQ-020 FLUSH: ex redirects SHALL be ignored (from squashed instructions); a wb redirect SHALL be handled as in RUN (issue or HOLD) and restart the count.
REQ-021 take_branch_o SHALL never be TAKE_BRANCH while stall_pipeline_i==STALL_PIPELINE.
REQ-022 Exactly one TAKE_BRANCH cycle SHALL be produced per accepted redirect; redirects are never lost or duplicated.
REQ-023 When take_branch_o is not TAKE_BRANCH, branch_pc_value_o SHALL be the pending register value.
REQ-024 Counter width SHALL be 3 bits; no wrap permitted (decrement saturates at 0).

Reset
REQ-025 reset_i SHALL force state RUN, counter 0, pending target 32'd0.
REQ-026 During and in the cycle after reset: take_branch_o not TAKE_BRANCH, flush_o=0, misaligned_o=0, branch_pc_value_o=0.
REQ-027 Reset mid-HOLD or mid-FLUSH SHALL discard the pending redirect with no TAKE_BRANCH issued.

Configuration
REQ-028 Macro REDIRECT_ALIGN_CHECK_EN defined: branch_pc_value_o SHALL have bit 0 forced to 0; misaligned_o=1 in any issue cycle whose raw target had bit 0 set.
REQ-029 REDIRECT_ALIGN_CHECK_EN undefined: target passed unmodified; misaligned_o tied 0.

Verification
REQ-030 Reset, no stall, ex_redirect_valid_i=1 pc=0x100 for one cycle -> same-cycle TAKE_BRANCH, value 0x100; flush_o high 2 cycles; RUN after.
REQ-031 ex pc=0x100 and wb pc=0x200 same cycle -> single TAKE_BRANCH with 0x200.
REQ-032 Stall 3 cycles, ex pc=0x40 in stall cycle 1, wb pc=0x80 in stall cycle 2 -> no TAKE_BRANCH while stalled; TAKE_BRANCH 0x80 in first unstalled cycle, once.
REQ-033 ex pc=0x100 issued, ex pc=0x300 next cycle (FLUSH) -> 0x300 ignored; wb pc=0x500 in FLUSH -> TAKE_BRANCH 0x500, flush count restarts.
REQ-034 HOLD with pending 0x40, reset_i pulsed -> no TAKE_BRANCH afterwards, all outputs at reset values.
REQ-035 With REDIRECT_ALIGN_CHECK_EN, ex pc=0x101 -> branch_pc_value_o=0x100, misaligned_o=1 that cycle; without it -> 0x101, misaligned_o=0.
